// File: rtl/uart_cmd_bridge_if.sv
// UART byte stream and SDRAM request bundle for uart_cmd_bridge.
// Signal names match the bridge pins; the slave modport is the bridge side.
interface uart_cmd_bridge_if #(
  parameter int AddrWidth = 22,
  parameter int DataWidth = 16
);
  logic [7:0]           i_rx_data;
  logic                 i_rx_rdy;
  logic                 o_rx_req;
  logic [7:0]           o_tx_data;
  logic                 o_tx_req;
  logic                 i_tx_rdy;
  logic                 o_wr_req;
  logic [AddrWidth-1:0] o_wr_addr;
  logic [DataWidth-1:0] o_wr_data;
  logic                 o_rd_req;
  logic [AddrWidth-1:0] o_rd_addr;
  logic [DataWidth-1:0] i_rd_data;
  logic                 i_rd_rdy;
  logic                 o_busy;

  modport slave (
    input  i_rx_data, i_rx_rdy, i_tx_rdy,
    input  i_rd_data, i_rd_rdy,
    output o_rx_req, o_tx_data, o_tx_req,
    output o_wr_req, o_wr_addr, o_wr_data,
    output o_rd_req, o_rd_addr, o_busy
  );

  modport master (
    output i_rx_data, i_rx_rdy, i_tx_rdy,
    output i_rd_data, i_rd_rdy,
    input  o_rx_req, o_tx_data, o_tx_req,
    input  o_wr_req, o_wr_addr, o_wr_data,
    input  o_rd_req, o_rd_addr, o_busy
  );
endinterface

// File: rtl/uart_cmd_bridge.sv
// UART command parser issuing SDRAM read/write requests.
// Define CMD_BRIDGE_WR_ACK_EN to reply 'k' (0x6B) after each write.
module uart_cmd_bridge #(
  parameter int AddrWidth     = 22,
  parameter int DataWidth     = 16,
  parameter int TimeoutCycles = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  uart_cmd_bridge_if.slave bus
);

  localparam logic [15:0] ToLast = 16'(TimeoutCycles - 1);
  localparam logic [7:0]  OpWr   = 8'h77;
  localparam logic [7:0]  OpRd   = 8'h72;

  typedef enum logic [3:0] {
    S_IDLE,
    S_OPCODE,
    S_ADDR,
    S_DATA,
    S_WR_ISSUE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_TX_HI,
    S_TX_LO,
`ifdef CMD_BRIDGE_WR_ACK_EN
    S_TX_ACK,
`endif
    S_TX_ERR
  } state_e;

  typedef enum logic [1:0] {
    P_SEND,
    P_WAIT_LO,
    P_WAIT_HI
  } txph_e;

  state_e               state_q, state_d;
  txph_e                txph_q, txph_d;
  logic [1:0]           bcnt_q, bcnt_d;
  logic [15:0]          tcnt_q, tcnt_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [DataWidth-1:0] rdat_q, rdat_d;
  logic [7:0]           err_q, err_d;
  logic [7:0]           op_q, op_d;
  logic                 is_wr_q, is_wr_d;
  logic                 txreq_q, txreq_d;
  logic [7:0]           txdat_q, txdat_d;
  logic                 wrreq_q, wrreq_d;
  logic                 rdreq_q, rdreq_d;
  logic                 busy_q;
  logic                 rxreq_q;
  logic                 en_q;

  logic                 rx_pop;
  logic                 tx_act;
  logic                 tx_done;
  logic [7:0]           tx_byte;

  // en_q keeps the pop low while reset is held and one cycle after.
  assign rx_pop = en_q && bus.i_rx_rdy && !rxreq_q &&
                  (state_q == S_IDLE ||
                   state_q == S_ADDR ||
                   state_q == S_DATA);

  assign bus.o_rx_req  = rx_pop;
  assign bus.o_tx_req  = txreq_q;
  assign bus.o_tx_data = txdat_q;
  assign bus.o_wr_req  = wrreq_q;
  assign bus.o_wr_addr = addr_q;
  assign bus.o_wr_data = data_q;
  assign bus.o_rd_req  = rdreq_q;
  assign bus.o_rd_addr = addr_q;
  assign bus.o_busy    = busy_q;

  always_comb begin
    state_d = state_q;
    txph_d  = txph_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdat_d  = rdat_q;
    err_d   = err_q;
    op_d    = op_q;
    is_wr_d = is_wr_q;
    txreq_d = 1'b0;
    txdat_d = txdat_q;
    wrreq_d = 1'b0;
    rdreq_d = 1'b0;
    tx_act  = 1'b0;
    tx_done = 1'b0;
    tx_byte = err_q;

    unique case (state_q)
      S_TX_HI: begin
        tx_act  = 1'b1;
        tx_byte = rdat_q[15:8];
      end
      S_TX_LO: begin
        tx_act  = 1'b1;
        tx_byte = rdat_q[7:0];
      end
`ifdef CMD_BRIDGE_WR_ACK_EN
      S_TX_ACK: begin
        tx_act  = 1'b1;
        tx_byte = 8'h6B;
      end
`endif
      S_TX_ERR: tx_act = 1'b1;
      default: ;
    endcase

    // Send, then see the transmitter go busy and idle again.
    if (tx_act) begin
      unique case (txph_q)
        P_SEND: begin
          if (bus.i_tx_rdy) begin
            txreq_d = 1'b1;
            txdat_d = tx_byte;
            txph_d  = P_WAIT_LO;
          end
        end
        P_WAIT_LO: begin
          if (!bus.i_tx_rdy) txph_d = P_WAIT_HI;
        end
        P_WAIT_HI: begin
          if (bus.i_tx_rdy) begin
            txph_d  = P_SEND;
            tx_done = 1'b1;
          end
        end
        default: txph_d = P_SEND;
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        if (rx_pop) begin
          op_d    = bus.i_rx_data;
          state_d = S_OPCODE;
        end
      end
      S_OPCODE: begin
        bcnt_d = 2'd0;
        unique case (1'b1)
          (op_q == OpWr): begin
            is_wr_d = 1'b1;
            state_d = S_ADDR;
          end
          (op_q == OpRd): begin
            is_wr_d = 1'b0;
            state_d = S_ADDR;
          end
          default: begin
            err_d   = 8'h3F;
            state_d = S_TX_ERR;
          end
        endcase
      end
      S_ADDR: begin
        if (rx_pop) begin
          addr_d = {addr_q[AddrWidth-9:0], bus.i_rx_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd2) begin
            bcnt_d  = 2'd0;
            state_d = is_wr_q ? S_DATA : S_RD_ISSUE;
          end
        end
      end
      S_DATA: begin
        if (rx_pop) begin
          data_d = {data_q[DataWidth-9:0], bus.i_rx_data};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd1) state_d = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: begin
        wrreq_d = 1'b1;
`ifdef CMD_BRIDGE_WR_ACK_EN
        state_d = S_TX_ACK;
`else
        state_d = S_IDLE;
`endif
      end
      S_RD_ISSUE: begin
        rdreq_d = 1'b1;
        tcnt_d  = 16'd0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (bus.i_rd_rdy) begin
          rdat_d  = bus.i_rd_data;
          state_d = S_TX_HI;
        end else if (tcnt_q == ToLast) begin
          err_d   = 8'hEE;
          state_d = S_TX_ERR;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      S_TX_HI: if (tx_done) state_d = S_TX_LO;
      S_TX_LO: if (tx_done) state_d = S_IDLE;
`ifdef CMD_BRIDGE_WR_ACK_EN
      S_TX_ACK: if (tx_done) state_d = S_IDLE;
`endif
      S_TX_ERR: if (tx_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      txph_q  <= P_SEND;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdat_q  <= '0;
      err_q   <= '0;
      op_q    <= '0;
      is_wr_q <= 1'b0;
      txreq_q <= 1'b0;
      txdat_q <= '0;
      wrreq_q <= 1'b0;
      rdreq_q <= 1'b0;
      busy_q  <= 1'b0;
      rxreq_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      txph_q  <= txph_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      op_q    <= op_d;
      is_wr_q <= is_wr_d;
      txreq_q <= txreq_d;
      txdat_q <= txdat_d;
      wrreq_q <= wrreq_d;
      rdreq_q <= rdreq_d;
      busy_q  <= (state_d != S_IDLE);
      rxreq_q <= rx_pop;
      en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge: UART queue, UART tx and SDRAM models.
// Build with CMD_BRIDGE_WR_ACK_EN to cover the write-ack variant.
module tb_uart_cmd_bridge;

`ifdef CMD_BRIDGE_WR_ACK_EN
  localparam int AckN = 1;
`else
  localparam int AckN = 0;
`endif

  logic clk;
  logic rst_n;

  uart_cmd_bridge_if #(.AddrWidth(22), .DataWidth(16)) bus ();

  uart_cmd_bridge #(
    .AddrWidth(22),
    .DataWidth(16),
    .TimeoutCycles(16)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_chk;
  int n_fail;

  int cyc, n_pop, n_wr, n_rd;
  int gap_viol, pulse_viol;
  int last_pop, wr_lat, rd_cyc, tx1_cyc;
  logic [21:0] wr_addr_s, rd_addr_s;
  logic [15:0] wr_data_s;
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  int tx_hold, rd_cnt, rd_lat;
  logic [15:0] rd_val;
  bit inject;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] txb(input int i);
    if (i < txq.size()) return txq[i];
    return 8'hxx;
  endfunction

  task automatic push(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rxq.size() == 0 && !bus.o_busy &&
          tx_hold == 0 && rd_cnt == 0) break;
    end
    chk(tag, 32'(i < 400), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Sample DUT at negedge, update models just after posedge.
  initial begin
    bit rxp, wrp, rdp, txp;
    bit prx, pwr, prd;
    bus.i_rx_data = 8'h00;
    bus.i_rx_rdy  = 1'b0;
    bus.i_tx_rdy  = 1'b1;
    bus.i_rd_data = 16'h0000;
    bus.i_rd_rdy  = 1'b0;
    prx = 0; pwr = 0; prd = 0;
    forever begin
      @(negedge clk);
      cyc++;
      rxp = bus.o_rx_req;
      wrp = bus.o_wr_req;
      rdp = bus.o_rd_req;
      txp = bus.o_tx_req;
      if (rxp) begin
        n_pop++;
        last_pop = cyc;
        if (prx) gap_viol++;
      end
      if (wrp) begin
        n_wr++;
        wr_lat    = cyc - last_pop;
        wr_addr_s = bus.o_wr_addr;
        wr_data_s = bus.o_wr_data;
        if (pwr) pulse_viol++;
      end
      if (rdp) begin
        n_rd++;
        rd_cyc    = cyc;
        rd_addr_s = bus.o_rd_addr;
        if (prd) pulse_viol++;
      end
      if (wrp && rdp) pulse_viol++;
      if (txp) begin
        txq.push_back(bus.o_tx_data);
        if (txq.size() == 1) tx1_cyc = cyc;
      end
      prx = rxp; pwr = wrp; prd = rdp;
      @(posedge clk);
      #1;
      if (rxp && rxq.size() != 0) void'(rxq.pop_front());
      bus.i_rx_rdy  = (rxq.size() != 0);
      bus.i_rx_data = (rxq.size() != 0) ? rxq[0] : 8'h00;
      if (txp) tx_hold = 3;
      else if (tx_hold != 0) tx_hold--;
      bus.i_tx_rdy = (tx_hold == 0);
      bus.i_rd_rdy = 1'b0;
      if (rd_cnt != 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          bus.i_rd_rdy  = 1'b1;
          bus.i_rd_data = rd_val;
        end
      end
      if (rdp && rd_lat >= 2) rd_cnt = rd_lat - 1;
      if (inject) begin
        bus.i_rd_rdy  = 1'b1;
        bus.i_rd_data = 16'h1234;
        inject = 0;
      end
    end
  end

  initial begin
    int p0, w0, r0;
    rst_n = 1'b0;
    rd_lat = 0;
    rd_val = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_rxreq", 32'(bus.o_rx_req), 32'd0);
    chk("rst_txreq", 32'(bus.o_tx_req), 32'd0);
    chk("rst_wrreq", 32'(bus.o_wr_req), 32'd0);
    chk("rst_rdreq", 32'(bus.o_rd_req), 32'd0);
    chk("rst_addr", 32'(bus.o_wr_addr), 32'd0);
    chk("rst_txdat", 32'(bus.o_tx_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0xBEEF to 0x012345
    txq.delete();
    w0 = n_wr;
    push(8'h77); push(8'h01); push(8'h23);
    push(8'h45); push(8'hBE); push(8'hEF);
    wait_idle("wr_idle");
    chk("wr_cnt", 32'(n_wr - w0), 32'd1);
    chk("wr_addr", 32'(wr_addr_s), 32'h012345);
    chk("wr_data", 32'(wr_data_s), 32'hBEEF);
    chk("wr_lat", 32'(wr_lat), 32'd2);
    chk("wr_tx_n", 32'(txq.size()), 32'(AckN));
`ifdef CMD_BRIDGE_WR_ACK_EN
    chk("wr_ack", 32'(txb(0)), 32'h6B);
`endif

    // Read 0x3FFFFF, A2 upper bits masked
    txq.delete();
    r0 = n_rd;
    w0 = n_wr;
    rd_lat = 5;
    rd_val = 16'hA55A;
    push(8'h72); push(8'h3F); push(8'hFF); push(8'hFF);
    wait_idle("rd_idle");
    chk("rd_cnt", 32'(n_rd - r0), 32'd1);
    chk("rd_addr", 32'(rd_addr_s), 32'h3FFFFF);
    chk("rd_tx_n", 32'(txq.size()), 32'd2);
    chk("rd_tx_hi", 32'(txb(0)), 32'hA5);
    chk("rd_tx_lo", 32'(txb(1)), 32'h5A);
    chk("rd_busy", 32'(bus.o_busy), 32'd0);
    chk("rd_no_wr", 32'(n_wr - w0), 32'd0);

    // Invalid opcode, then a normal read
    txq.delete();
    r0 = n_rd;
    w0 = n_wr;
    p0 = n_pop;
    push(8'h41);
    wait_idle("bad_idle");
    chk("bad_pops", 32'(n_pop - p0), 32'd1);
    chk("bad_tx_n", 32'(txq.size()), 32'd1);
    chk("bad_tx", 32'(txb(0)), 32'h3F);
    chk("bad_noreq", 32'((n_rd - r0) + (n_wr - w0)), 32'd0);
    txq.delete();
    rd_val = 16'h1357;
    push(8'h72); push(8'h00); push(8'h00); push(8'h10);
    wait_idle("rd2_idle");
    chk("rd2_cnt", 32'(n_rd - r0), 32'd1);
    chk("rd2_addr", 32'(rd_addr_s), 32'h000010);
    chk("rd2_tx_hi", 32'(txb(0)), 32'h13);
    chk("rd2_tx_lo", 32'(txb(1)), 32'h57);

    // Timeout with no read response, then a late response
    txq.delete();
    rd_lat = 0;
    push(8'h72); push(8'h00); push(8'h00); push(8'h01);
    wait_idle("to_idle");
    chk("to_tx_n", 32'(txq.size()), 32'd1);
    chk("to_tx", 32'(txb(0)), 32'hEE);
    chk("to_lat", 32'(tx1_cyc - rd_cyc), 32'd17);
    r0 = n_rd;
    inject = 1;
    repeat (10) @(negedge clk);
    chk("late_tx_n", 32'(txq.size()), 32'd1);
    chk("late_busy", 32'(bus.o_busy), 32'd0);
    chk("late_rd", 32'(n_rd - r0), 32'd0);

    // Reset in the middle of a write
    txq.delete();
    w0 = n_wr;
    push(8'h77); push(8'h00); push(8'h00);
    for (int i = 0; i < 50 && rxq.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.o_busy), 32'd0);
    chk("mid_rst_addr", 32'(bus.o_wr_addr), 32'd0);
    chk("mid_rst_reqs",
        32'({bus.o_rx_req, bus.o_tx_req, bus.o_wr_req, bus.o_rd_req}),
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_no_wr", 32'(n_wr - w0), 32'd0);
    push(8'h77); push(8'h00); push(8'h00);
    push(8'h08); push(8'h12); push(8'h34);
    wait_idle("mid_wr_idle");
    chk("mid_wr_cnt", 32'(n_wr - w0), 32'd1);
    chk("mid_wr_addr", 32'(wr_addr_s), 32'h000008);
    chk("mid_wr_data", 32'(wr_data_s), 32'h1234);
    chk("mid_tx_n", 32'(txq.size()), 32'(AckN));

    // Back-to-back write and read with rx always ready
    txq.delete();
    w0 = n_wr;
    r0 = n_rd;
    p0 = n_pop;
    rd_lat = 5;
    rd_val = 16'hC33C;
    push(8'h77); push(8'h0A); push(8'hBC); push(8'hDE);
    push(8'h55); push(8'hAA);
    push(8'h72); push(8'h00); push(8'h00); push(8'h20);
    wait_idle("b2b_idle");
    chk("b2b_pops", 32'(n_pop - p0), 32'd10);
    chk("b2b_wr", 32'(n_wr - w0), 32'd1);
    chk("b2b_rd", 32'(n_rd - r0), 32'd1);
    chk("b2b_wr_addr", 32'(wr_addr_s), 32'h0ABCDE);
    chk("b2b_wr_data", 32'(wr_data_s), 32'h55AA);
    chk("b2b_rd_addr", 32'(rd_addr_s), 32'h000020);
    chk("b2b_tx_n", 32'(txq.size()), 32'(AckN + 2));
    chk("b2b_tx_hi", 32'(txb(AckN)), 32'hC3);
    chk("b2b_tx_lo", 32'(txb(AckN + 1)), 32'h3C);

    chk("rx_guard", 32'(gap_viol), 32'd0);
    chk("req_pulses", 32'(pulse_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
